// File: rtl/display_pkg.sv
// Shared seven-segment codes (active-low {g,f,e,d,c,b,a}) and the scan digit index.
package display_pkg;
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} dig_e;
endpackage

// File: rtl/bcd_seg_decode.sv
// Combinational decimal digit to active-low seven-segment pattern; out-of-range shows blank.
module bcd_seg_decode
   import display_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);
   always_comb begin
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end
endmodule

// File: rtl/result_display.sv
// Captures a sign-magnitude result and scans it onto a 4-digit common-anode display
// with a blanked lead-in at each digit slot; also drives zero LED and sticky format error.
module result_display
   import display_pkg::*;
#(
   parameter int unsigned REFRESH_DIV  = 50000,
   parameter int unsigned BLANK_CYCLES = 500
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [4:0] result_in,
   input  logic       zeroflag_in,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic       zero_led,
   output logic       fmt_err
);
   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   logic [4:0]    stored_q, stored_d;
   logic          zero_q, zero_d;
   logic          fmt_err_q, fmt_err_d;
   logic [CW-1:0] cnt_q, cnt_d;
   dig_e          d_q, d_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;

   logic [3:0] mag, ones, dig_val;
   logic       tens;
   logic [6:0] dec_seg, pat;

   always_comb begin
      mag     = stored_q[3:0];
      tens    = (mag >= 4'd10);
      ones    = tens ? (mag - 4'd10) : mag;
      dig_val = (d_q == DIG1) ? 4'd1 : ones;
   end

   bcd_seg_decode u_dec (.digit(dig_val), .seg(dec_seg));

   always_comb begin
      stored_d  = stored_q;
      zero_d    = zero_q;
      fmt_err_d = fmt_err_q;
      if (load) begin
         stored_d  = result_in;
         zero_d    = zeroflag_in;
         fmt_err_d = fmt_err_q | (zeroflag_in != (result_in[3:0] == 4'd0));
      end

      cnt_d = cnt_q + 1'b1;
      d_d   = d_q;
      if (cnt_q == CW'(REFRESH_DIV - 1)) begin
         cnt_d = '0;
         d_d   = dig_e'(d_q + 2'd1);
      end

      // Negative zero is shown without a minus sign.
      case (d_q)
         DIG0:    pat = dec_seg;
         DIG1:    pat = tens ? dec_seg : SEG_BLANK;
         DIG2:    pat = (stored_q[4] && (mag != 4'd0)) ? SEG_MINUS : SEG_BLANK;
         default: pat = SEG_BLANK;
      endcase

      if (cnt_q < CW'(BLANK_CYCLES)) begin
         an_d  = 4'b1111;
         seg_d = SEG_BLANK;
      end else begin
         an_d  = ~(4'b0001 << d_q);
         seg_d = pat;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stored_q  <= '0;
         zero_q    <= 1'b0;
         fmt_err_q <= 1'b0;
         cnt_q     <= '0;
         d_q       <= DIG0;
         an_q      <= 4'b1111;
         seg_q     <= SEG_BLANK;
      end else begin
         stored_q  <= stored_d;
         zero_q    <= zero_d;
         fmt_err_q <= fmt_err_d;
         cnt_q     <= cnt_d;
         d_q       <= d_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
      end
   end

   assign seg      = seg_q;
   assign an       = an_q;
   assign zero_led = zero_q;
   assign fmt_err  = fmt_err_q;
endmodule

// File: tb/tb_result_display.sv
// Scoreboarded bench for result_display with REFRESH_DIV=8, BLANK_CYCLES=1.
module tb_result_display;
   localparam int RD = 8;
   localparam int BC = 1;
   localparam logic [6:0] B = 7'b1111111;

   typedef struct {
      int         cyc;
      logic [3:0] an;
      logic [6:0] seg;
      logic       zl;
      logic       fe;
   } exp_t;

   localparam logic [3:0] AN [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   // Hand-built digit tables {d3,d2,d1,d0}
   localparam logic [3:0][6:0] D_ZERO = {B, B, B, 7'b1000000};
   localparam logic [3:0][6:0] D_NEG6 = {B, 7'b0111111, B, 7'b0000010};
   localparam logic [3:0][6:0] D_12   = {B, B, 7'b1111001, 7'b0100100};
   localparam logic [3:0][6:0] D_3    = {B, B, B, 7'b0110000};
   localparam logic [3:0][6:0] D_5    = {B, B, B, 7'b0010010};
   localparam logic [3:0][6:0] D_1    = {B, B, B, 7'b1111001};

   logic       clk, rst_n, load, zeroflag_in;
   logic [4:0] result_in;
   logic [6:0] seg;
   logic [3:0] an;
   logic       zero_led, fmt_err;

   int checks = 0;
   int errors = 0;
   int cyc;
   exp_t sb[$];

   logic [3:0][6:0] exp_dig;
   logic            exp_zl, exp_fe;

   result_display #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .result_in(result_in),
      .zeroflag_in(zeroflag_in), .seg(seg), .an(an),
      .zero_led(zero_led), .fmt_err(fmt_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n)
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;

   task automatic check(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got %b want %b", name, k, act, exp);
      end
   endtask

   // Monitor: pops every expectation tagged with the edge just completed.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         if (sb[0].cyc < cyc) begin
            errors++;
            $display("FAIL missed_expectation cyc=%0d got none want cyc=%0d", cyc, sb[0].cyc);
         end else begin
            check("an",       cyc, {4'b0, an},       {4'b0, sb[0].an});
            check("seg",      cyc, {1'b0, seg},      {1'b0, sb[0].seg});
            check("zero_led", cyc, {7'b0, zero_led}, {7'b0, sb[0].zl});
            check("fmt_err",  cyc, {7'b0, fmt_err},  {7'b0, sb[0].fe});
         end
         void'(sb.pop_front());
      end
   end

   // One clock: push the expectation for the coming edge, drive inputs, advance.
   task automatic step(input bit ld, input logic [4:0] r, input logic zf,
                       input logic [3:0][6:0] nd, input logic nzl, input logic nfe);
      exp_t e;
      int k, slot, dg;
      k    = cyc + 1;
      slot = (k - 1) % RD;
      dg   = ((k - 1) / RD) % 4;
      if (ld) begin
         exp_zl = nzl;
         exp_fe = nfe;
      end
      e.cyc = k;
      e.an  = (slot < BC) ? 4'b1111 : AN[dg];
      e.seg = (slot < BC) ? B : exp_dig[dg];
      e.zl  = exp_zl;
      e.fe  = exp_fe;
      sb.push_back(e);
      load        = ld;
      result_in   = r;
      zeroflag_in = zf;
      @(posedge clk);
      if (ld) exp_dig = nd;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 5'd0, 1'b0, exp_dig, exp_zl, exp_fe);
   endtask

   task automatic reset_expect();
      exp_dig = D_ZERO;
      exp_zl  = 1'b0;
      exp_fe  = 1'b0;
   endtask

   task automatic async_reset_check(input string tag);
      check({tag, "_an"},  cyc, {4'b0, an},       8'h0F);
      check({tag, "_seg"}, cyc, {1'b0, seg},      8'h7F);
      check({tag, "_zl"},  cyc, {7'b0, zero_led}, 8'h00);
      check({tag, "_fe"},  cyc, {7'b0, fmt_err},  8'h00);
   endtask

   initial begin
      rst_n = 1'b1; load = 1'b0; result_in = '0; zeroflag_in = 1'b0;
      reset_expect();
      #1 rst_n = 1'b0;
      #2 async_reset_check("rst0");
      @(negedge clk);
      rst_n = 1'b1;

      // Power-up: "0" on DIG0, rest blank, one full scan
      idle(32);

      // -6: loaded right at a slot boundary of DIG0
      step(1'b1, 5'b10110, 1'b0, D_NEG6, 1'b0, 1'b0);
      idle(33);

      // 12
      step(1'b1, 5'b01100, 1'b0, D_12, 1'b0, 1'b0);
      idle(33);

      // negative zero
      step(1'b1, 5'b10000, 1'b1, D_ZERO, 1'b1, 1'b0);
      idle(33);

      // zero flag mismatch: 3 with zeroflag set
      step(1'b1, 5'b00011, 1'b1, D_3, 1'b1, 1'b1);
      idle(5);

      // mid-slot load during unblanked DIG0 showing '3'
      for (int i = 0; i < 40 && !((cyc % RD) == 3 && ((cyc / RD) % 4) == 0); i++) idle(1);
      step(1'b1, 5'b00101, 1'b0, D_5, 1'b0, 1'b1);
      idle(20);

      // valid load does not clear sticky error; back-to-back loads, last wins
      step(1'b1, 5'b11111, 1'b0, {B, 7'b0111111, 7'b1111001, 7'b0010010}, 1'b0, 1'b1);
      step(1'b1, 5'b00001, 1'b0, D_1, 1'b0, 1'b1);
      idle(33);

      // mid-scan asynchronous reset
      #2 rst_n = 1'b0;
      #1 async_reset_check("rst_mid");
      reset_expect();
      @(negedge clk);
      rst_n = 1'b1;
      idle(12);

      @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
